instr_mem_loader: RTL and testbench

- Writer side of the processor's instruction store. Fills a writable instruction RAM at boot, so programs no longer have to be hard-coded into a fixed table.
- Consumes a serial byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them to consecutive word addresses.
- Holds the ARMv4 core in reset until a complete, checksum-verified image is loaded.

---
 rtl/instr_mem_loader.sv | 110 +++++++++++
 tb/tb_instr_mem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot-time instruction RAM loader: assembles a UART byte frame into 32-bit words,
// verifies its XOR checksum and releases the core only after a good image.
module instr_mem_loader #(
    parameter int          addr_bits      = 8,
    parameter int          data_width     = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  ram_we,
    output logic [addr_bits-1:0]  ram_addr,
    output logic [data_width-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int AW = addr_bits + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, CHECK, DONE, ERROR
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] n_words, word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic [23:0]   asm_q;
    logic [TW-1:0] tcnt;
    logic          active, timed_out, n_bad, last_word, is_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        active    = (state == COUNT) || (state == DATA) || (state == CHECK);
        timed_out = active && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
        n_bad     = (rx_data == 8'h00) || (int'(rx_data) > (1 << addr_bits));
        last_word = (byte_idx == 2'd3) && ((word_idx + ONE) == n_words);
        is_sync   = rx_valid && (rx_data == SYNC_BYTE);
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (is_sync) state_nxt = COUNT;
            end
            COUNT: begin
                if (rx_valid) state_nxt = n_bad ? ERROR : DATA;
            end
            DATA: begin
                if (rx_valid && last_word) state_nxt = CHECK;
            end
            CHECK: begin
                if (rx_valid) state_nxt = (rx_data == csum) ? DONE : ERROR;
            end
            default: state_nxt = IDLE;
        endcase
        if (timed_out) state_nxt = ERROR;
    end

    // Status flags follow the next state so they are registered yet aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            asm_q      <= '0;
            tcnt       <= '0;
        end else begin
            ram_we     <= 1'b0;
            cpu_hold   <= (state_nxt != DONE);
            load_done  <= (state_nxt == DONE);
            load_error <= (state_nxt == ERROR);
            if (!active || rx_valid) tcnt <= '0;
            else                     tcnt <= tcnt + TW'(1);
            if (rx_valid && state == COUNT) begin
                n_words  <= AW'(rx_data);
                word_idx <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end
            if (rx_valid && state == DATA) begin
                csum     <= csum ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    ram_we    <= 1'b1;
                    ram_addr  <= word_idx[addr_bits-1:0];
                    ram_wdata <= {rx_data, asm_q};
                    word_idx  <= word_idx + ONE;
                end else begin
                    asm_q[8*byte_idx +: 8] <= rx_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected RAM writes are queued by the
// stimulus and matched by a negedge monitor, status flags checked directly.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        cpu_hold, load_done, load_error;

    instr_mem_loader #(
        .addr_bits(8), .data_width(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  ncyc = 0;
    int  passed = 0;
    int  total = 0;

    // Monitor: every write pulse must match the head of the queue, on time
    always @(negedge clk) begin
        ncyc++;
        if (ram_we) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (ram_addr == e.addr && ram_wdata == e.data && ncyc == e.cyc)
                    passed++;
                else
                    $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             ram_addr, ram_wdata, ncyc, e.addr, e.data, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic status(input string name, input logic h, input logic d, input logic e);
        chk({name, "_hold"}, 32'(cpu_hold), 32'(h));
        chk({name, "_done"}, 32'(load_done), 32'(d));
        chk({name, "_err"}, 32'(load_error), 32'(e));
    endtask

    // Called just before driving a word's 4th byte
    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = ncyc + 2;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nominal(input logic [7:0] c);
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h0B); send(8'hA0);
        expect_wr(8'd0, 32'he3a00b01); send(8'hE3);
        send(8'h05); send(8'h1C); send(8'hA0);
        expect_wr(8'd1, 32'he3a01c05); send(8'hE3);
        send(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        idle(2);
        reset = 1'b0;
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        status("rst", 1'b1, 1'b0, 1'b0);

        send(8'h00); send(8'hFF); send(8'h7D);
        idle(2);
        status("garbage", 1'b1, 1'b0, 1'b0);
        send(8'hA5); send(8'h00);
        status("zero_n", 1'b1, 1'b0, 1'b1);
        idle(2);

        nominal(8'h13);
        status("nominal", 1'b0, 1'b1, 1'b0);
        idle(3);

        send(8'hA5);
        status("reload_sync", 1'b1, 1'b0, 1'b0);
        send(8'h01); send(8'h50); send(8'h00); send(8'hA0);
        expect_wr(8'd0, 32'he3a00050); send(8'hE3);
        send(8'h13);
        status("b2b", 1'b0, 1'b1, 1'b0);
        idle(2);

        nominal(8'h14);
        status("bad_csum", 1'b1, 1'b0, 1'b1);
        idle(2);

        send(8'hA5); send(8'h01); send(8'h50); send(8'h00); send(8'hA0);
        expect_wr(8'd0, 32'he3a00050); send(8'hE3);
        send(8'h3D);
        status("csum_3d", 1'b1, 1'b0, 1'b1);
        idle(2);

        send(8'hA5); send(8'h01); send(8'h0A);
        idle(19);
        chk("tmo_early", 32'(load_error), 32'd0);
        idle(1);
        status("timeout", 1'b1, 1'b0, 1'b1);
        idle(2);

        send(8'hA5); send(8'h01); send(8'h11); send(8'h22);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        chk("arst_wdata", ram_wdata, 32'd0);
        status("arst", 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        send(8'hA5); send(8'h01); send(8'h78); send(8'h56); send(8'h34);
        expect_wr(8'd0, 32'h12345678); send(8'h12);
        send(8'h08);
        status("after_rst", 1'b0, 1'b1, 1'b0);

        idle(4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
